// File: rtl/fp_align_stage.sv
// Two-stage FP32 adder front end: unpack/compare operands, then align the smaller mantissa with sticky.
// Optional macro FP_ALIGN_DENORM_EN keeps subnormals; when undefined, exp==0 operands flush to signed zero.
module fp_align_stage #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int GRS_W = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   OP_A,
  input  logic [EXP_W+MAN_W:0]   OP_B,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   OP_A_S,
  output logic                   OP_B_S,
  output logic                   op_q,
  output logic                   swap,
  output logic                   equal,
  output logic                   eff_sub,
  output logic [EXP_W-1:0]       exp_big,
  output logic [MAN_W+GRS_W:0]   man_big,
  output logic [MAN_W+GRS_W:0]   man_small
);

  localparam int          HW = MAN_W + 1;
  localparam int unsigned MW = MAN_W + 1 + GRS_W;

  // Right shift that folds every discarded bit into the LSB.
  function automatic logic [MW-1:0] align_sticky(input logic [MW-1:0] m,
                                                 input logic [EXP_W-1:0] sh);
    logic [MW-1:0] mask;
    logic [MW-1:0] r;
    if (32'(sh) >= MW) begin
      r    = '0;
      r[0] = |m;
    end else begin
      mask = ~({MW{1'b1}} << sh);
      r    = m >> sh;
      r[0] = r[0] | (|(m & mask));
    end
    return r;
  endfunction

  logic                   a_s, b_s;
  logic [EXP_W-1:0]       a_e, b_e, a_ee, b_ee;
  logic [MAN_W-1:0]       a_f, b_f;
  logic                   a_h, b_h;
  logic [EXP_W+MAN_W-1:0] a_key, b_key;

  assign a_s = OP_A[EXP_W+MAN_W];
  assign b_s = OP_B[EXP_W+MAN_W];
  assign a_e = OP_A[EXP_W+MAN_W-1 -: EXP_W];
  assign b_e = OP_B[EXP_W+MAN_W-1 -: EXP_W];
  assign a_h = |a_e;
  assign b_h = |b_e;

`ifdef FP_ALIGN_DENORM_EN
  assign a_f  = OP_A[MAN_W-1:0];
  assign b_f  = OP_B[MAN_W-1:0];
  assign a_ee = (a_e == '0) ? EXP_W'(1) : a_e;
  assign b_ee = (b_e == '0) ? EXP_W'(1) : b_e;
`else
  assign a_f  = (a_e == '0) ? '0 : OP_A[MAN_W-1:0];
  assign b_f  = (b_e == '0) ? '0 : OP_B[MAN_W-1:0];
  assign a_ee = a_e;
  assign b_ee = b_e;
`endif

  assign a_key = {a_e, a_f};
  assign b_key = {b_e, b_f};

  // Stage 1 next-state: magnitude order, exponent difference, unpacked mantissas
  logic             swap_p1_d, equal_p1_d;
  logic [EXP_W-1:0] exp_p1_d, diff_p1_d;
  logic [HW-1:0]    mbig_p1_d, msml_p1_d;

  always_comb begin
    swap_p1_d  = b_key > a_key;
    equal_p1_d = a_key == b_key;
    if (swap_p1_d) begin
      exp_p1_d  = b_ee;
      diff_p1_d = b_ee - a_ee;
      mbig_p1_d = {b_h, b_f};
      msml_p1_d = {a_h, a_f};
    end else begin
      exp_p1_d  = a_ee;
      diff_p1_d = a_ee - b_ee;
      mbig_p1_d = {a_h, a_f};
      msml_p1_d = {b_h, b_f};
    end
  end

  logic             vld_p1_q, a_s_p1_q, b_s_p1_q, op_p1_q, swap_p1_q, equal_p1_q;
  logic [EXP_W-1:0] exp_p1_q, diff_p1_q;
  logic [HW-1:0]    mbig_p1_q, msml_p1_q;

  logic             vld_p2_q, a_s_p2_q, b_s_p2_q, op_p2_q, swap_p2_q, equal_p2_q, eff_p2_q;
  logic [EXP_W-1:0] exp_p2_q;
  logic [MW-1:0]    mbig_p2_q, msml_p2_q;

  logic             s1_adv, s2_adv;
  logic             eff_p2_d;
  logic [MW-1:0]    mbig_p2_d, msml_p2_d;

  assign s2_adv   = ~vld_p2_q | out_ready;
  assign s1_adv   = ~vld_p1_q | s2_adv;
  assign in_ready = s1_adv;

  // Stage 2 next-state: alignment of the smaller operand
  assign eff_p2_d  = a_s_p1_q ^ b_s_p1_q ^ op_p1_q;
  assign mbig_p2_d = {mbig_p1_q, {GRS_W{1'b0}}};
  assign msml_p2_d = align_sticky({msml_p1_q, {GRS_W{1'b0}}}, diff_p1_q);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      vld_p1_q   <= 1'b0;
      a_s_p1_q   <= 1'b0;
      b_s_p1_q   <= 1'b0;
      op_p1_q    <= 1'b0;
      swap_p1_q  <= 1'b0;
      equal_p1_q <= 1'b0;
      exp_p1_q   <= '0;
      diff_p1_q  <= '0;
      mbig_p1_q  <= '0;
      msml_p1_q  <= '0;
      vld_p2_q   <= 1'b0;
      a_s_p2_q   <= 1'b0;
      b_s_p2_q   <= 1'b0;
      op_p2_q    <= 1'b0;
      swap_p2_q  <= 1'b0;
      equal_p2_q <= 1'b0;
      eff_p2_q   <= 1'b0;
      exp_p2_q   <= '0;
      mbig_p2_q  <= '0;
      msml_p2_q  <= '0;
    end else begin
      if (s1_adv) begin
        vld_p1_q <= in_valid;
        if (in_valid) begin
          a_s_p1_q   <= a_s;
          b_s_p1_q   <= b_s;
          op_p1_q    <= op;
          swap_p1_q  <= swap_p1_d;
          equal_p1_q <= equal_p1_d;
          exp_p1_q   <= exp_p1_d;
          diff_p1_q  <= diff_p1_d;
          mbig_p1_q  <= mbig_p1_d;
          msml_p1_q  <= msml_p1_d;
        end
      end
      // Stage 2 holds its contents while downstream stalls
      if (s2_adv) begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) begin
          a_s_p2_q   <= a_s_p1_q;
          b_s_p2_q   <= b_s_p1_q;
          op_p2_q    <= op_p1_q;
          swap_p2_q  <= swap_p1_q;
          equal_p2_q <= equal_p1_q;
          eff_p2_q   <= eff_p2_d;
          exp_p2_q   <= exp_p1_q;
          mbig_p2_q  <= mbig_p2_d;
          msml_p2_q  <= msml_p2_d;
        end
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign OP_A_S    = a_s_p2_q;
  assign OP_B_S    = b_s_p2_q;
  assign op_q      = op_p2_q;
  assign swap      = swap_p2_q;
  assign equal     = equal_p2_q;
  assign eff_sub   = eff_p2_q;
  assign exp_big   = exp_p2_q;
  assign man_big   = mbig_p2_q;
  assign man_small = msml_p2_q;

endmodule
